// File: rtl/cim_cmd_seq.sv
// Bus-mapped command sequencer for Basic_GeMM_CIM. It handles weight loads and
// multiply-accumulate bursts. All CIM controls are registered from next-state logic.
module cim_cmd_seq #(
  parameter int IN_DEPTH = 4,
  parameter int CIM_LAT  = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        SEL,
  input  logic        WR,
  input  logic        RD,
  input  logic [4:0]  A,
  input  logic [31:0] DATAO,
  output logic [31:0] DATAI,
  input  logic [31:0] cim_output,
  output logic        we,
  output logic        cime,
  output logic        partial_sum_e,
  output logic        reset_output_reg,
  output logic [3:0]  output_reg,
  output logic [31:0] address,
  output logic [31:0] input_data
);
  localparam int KW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_WAIT, S_CAPT} state_e;

  state_e        state_q, state_d;
  logic [7:0]    k_q, k_d, wcnt_q, wcnt_d;
  logic [31:0]   addr_q, result_q, datai_q;
  logic [7:0]    nrows_q;
  logic [3:0]    osel_q;
  logic [31:0]   inbuf_q [IN_DEPTH];
  logic          done_q, err_q;
  logic          we_q, we_d, cime_q, cime_d, pse_q, pse_d, rst_q, rst_d;
  logic [31:0]   caddr_q, caddr_d, cdata_q, cdata_d;
  logic          wr_s, rd_s, busy_s, start_ok_s, inbuf_hit_s;
  logic [KW-1:0] ibidx_s;
  logic [31:0]   rdata_s;

  assign wr_s        = SEL & WR;
  assign rd_s        = SEL & RD;
  assign busy_s      = (state_q != S_IDLE);
  assign start_ok_s  = (nrows_q != 8'd0) && (nrows_q <= 8'(IN_DEPTH));
  assign inbuf_hit_s = ({27'd0, A} >= 32'd8) && ({27'd0, A} < 32'(8 + IN_DEPTH));
  assign ibidx_s     = KW'(A - 5'd8);

  // Next state and the CIM strobe values to present during the following cycle
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    we_d    = 1'b0;
    cime_d  = 1'b0;
    pse_d   = 1'b0;
    rst_d   = 1'b0;
    caddr_d = 32'd0;
    cdata_d = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (wr_s && (A == 5'd0) && DATAO[0] && start_ok_s) begin
          state_d = S_CLR;
          rst_d   = 1'b1;
        end else if (wr_s && (A == 5'd4)) begin
          we_d    = 1'b1;
          caddr_d = addr_q;
          cdata_d = DATAO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        state_d = S_ISSUE;
        k_d     = 8'd0;
        cime_d  = 1'b1;
        caddr_d = addr_q;
        cdata_d = inbuf_q[0];
      end
      S_ISSUE: begin
        if (k_q == (nrows_q - 8'd1)) begin
          state_d = S_WAIT;
          wcnt_d  = 8'd0;
        end else begin
          k_d     = k_q + 8'd1;
          cime_d  = 1'b1;
          pse_d   = 1'b1;
          caddr_d = addr_q + {24'd0, k_d};
          cdata_d = inbuf_q[k_d[KW-1:0]];
        end
      end
      S_WAIT: begin
        if (wcnt_q == 8'(CIM_LAT - 1)) begin
          state_d = S_CAPT;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_CAPT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered CIM controls
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= S_IDLE;
      k_q     <= 8'd0;
      wcnt_q  <= 8'd0;
      we_q    <= 1'b0;
      cime_q  <= 1'b0;
      pse_q   <= 1'b0;
      rst_q   <= 1'b0;
      caddr_q <= 32'd0;
      cdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      cime_q  <= cime_d;
      pse_q   <= pse_d;
      rst_q   <= rst_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

  // Read-data mux over the register window
  always_comb begin
    rdata_s = 32'd0;
    case (A)
      5'd0: rdata_s = {29'd0, err_q, done_q, busy_s};
      5'd1: rdata_s = addr_q;
      5'd2: rdata_s = {24'd0, nrows_q};
      5'd3: rdata_s = {28'd0, osel_q};
      5'd5: rdata_s = result_q;
      default: begin
        if (inbuf_hit_s) rdata_s = inbuf_q[ibidx_s];
        else             rdata_s = 32'd0;
      end
    endcase
  end

  // Bus-visible registers; capture of the CIM result wins over a same-cycle clear
  always_ff @(posedge CLK) begin
    if (RES) begin
      addr_q   <= 32'd0;
      nrows_q  <= 8'd0;
      osel_q   <= 4'd0;
      result_q <= 32'd0;
      datai_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < IN_DEPTH; i++) inbuf_q[i] <= 32'd0;
    end else begin
      if (rd_s) datai_q <= rdata_s;
      if (wr_s && (A == 5'd0)) begin
        if (DATAO[1]) begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
        if (DATAO[0] && !busy_s) begin
          if (start_ok_s) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
      if (wr_s && !busy_s) begin
        case (A)
          5'd1: addr_q  <= DATAO;
          5'd2: nrows_q <= DATAO[7:0];
          5'd3: osel_q  <= DATAO[3:0];
          5'd4: addr_q  <= addr_q + 32'd1;
          default: begin
            if (inbuf_hit_s) inbuf_q[ibidx_s] <= DATAO;
          end
        endcase
      end
      if (state_q == S_CAPT) begin
        result_q <= cim_output;
        done_q   <= 1'b1;
      end
    end
  end

  assign DATAI            = datai_q;
  assign we               = we_q;
  assign cime             = cime_q;
  assign partial_sum_e    = pse_q;
  assign reset_output_reg = rst_q;
  assign output_reg       = osel_q;
  assign address          = caddr_q;
  assign input_data       = cdata_q;

endmodule
